// File: rtl/sd_load_ctrl_if.sv
// Byte-stream input and memory-write handshake between the SD loader and its neighbours.
// master: the load controller side; slave: the reader/memory-controller side.
interface sd_load_ctrl_if;
   logic        in_valid;
   logic [7:0]  in_byte;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;

   modport master (
      input  in_valid, in_byte, mem_ack,
      output mem_req, mem_addr, mem_wdata
   );

   modport slave (
      output in_valid, in_byte, mem_ack,
      input  mem_req, mem_addr, mem_wdata
   );
endinterface

// File: rtl/sd_load_ctrl.sv
// Boot image loader: packs SD file bytes into little-endian words, queues them, writes them to memory.
// Optional running word checksum is built only when SDLOAD_CHECKSUM_EN is defined.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for enable
// ST_RUN   | accepting bytes, packing words, pushing full words
// ST_FLUSH | pushing the zero-padded partial last word (one cycle)
// ST_DRAIN | all bytes taken, waiting for the word queue to empty
// ST_DONE  | image written; only reset leaves
module sd_load_ctrl #(
   parameter int unsigned BIN_SIZE   = 4096,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic           clk27mhz,
   input  logic           resetn,
   input  logic           enable,
   sd_load_ctrl_if.master bus,
   output logic           busy,
   output logic           done,
   output logic           overflow,
   output logic [31:0]    checksum
);

   localparam int CW = $clog2(BIN_SIZE + 1);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] LAST_BYTE = CW'(BIN_SIZE - 1);
   localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {ST_IDLE, ST_RUN, ST_FLUSH, ST_DRAIN, ST_DONE} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] bcnt;
   logic [1:0]    lane;
   logic [23:0]   pack;
   logic [31:0]   fifo_mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   fcnt;
   logic [31:0]   addr;
   logic          take_byte, push, pop, push_ok, fifo_full, fifo_empty;
   logic [31:0]   push_data;

   assign fifo_empty = (fcnt == '0);
   assign fifo_full  = (fcnt == FULL_CNT);
   assign pop        = !fifo_empty && bus.mem_ack;
   // a pop in the same cycle frees the slot, so a push into a full queue still lands
   assign push_ok    = push && (!fifo_full || pop);

   always_ff @(posedge clk27mhz or negedge resetn) begin
      if (!resetn) state <= ST_IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      take_byte = 1'b0;
      push      = 1'b0;
      push_data = {bus.in_byte, pack};
      case (state)
         ST_IDLE: if (enable) state_nxt = ST_RUN;
         ST_RUN: begin
            if (enable && bus.in_valid) begin
               take_byte = 1'b1;
               push      = (lane == 2'd3);
               if (bcnt == LAST_BYTE) state_nxt = (lane == 2'd3) ? ST_DRAIN : ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            push      = 1'b1;
            push_data = {8'h00, pack};
            state_nxt = ST_DRAIN;
         end
         ST_DRAIN: if (fifo_empty) state_nxt = ST_DONE;
         ST_DONE:  state_nxt = ST_DONE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // lanes above the current one are always zero, which gives the padding for free
   always_ff @(posedge clk27mhz or negedge resetn) begin
      if (!resetn) begin
         bcnt <= '0;
         lane <= 2'd0;
         pack <= 24'h0;
      end else if (take_byte) begin
         bcnt <= bcnt + CW'(1);
         lane <= lane + 2'd1;
         case (lane)
            2'd0:    pack[7:0]   <= bus.in_byte;
            2'd1:    pack[15:8]  <= bus.in_byte;
            2'd2:    pack[23:16] <= bus.in_byte;
            default: pack        <= 24'h0;
         endcase
      end
   end

   always_ff @(posedge clk27mhz or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < int'(FIFO_DEPTH); i++) fifo_mem[i] <= 32'h0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fcnt     <= '0;
         addr     <= BASE_ADDR;
         overflow <= 1'b0;
      end else begin
         if (push_ok) begin
            fifo_mem[wr_ptr] <= push_data;
            wr_ptr           <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
            addr   <= addr + 32'd4;
         end
         case ({push_ok, pop})
            2'b10:   fcnt <= fcnt + (AW + 1)'(1);
            2'b01:   fcnt <= fcnt - (AW + 1)'(1);
            default: fcnt <= fcnt;
         endcase
         if (push && !push_ok) overflow <= 1'b1;
      end
   end

`ifdef SDLOAD_CHECKSUM_EN
   logic [31:0] csum;
   always_ff @(posedge clk27mhz or negedge resetn) begin
      if (!resetn)                      csum <= 32'h0;
      else if (pop && state != ST_DONE) csum <= csum + bus.mem_wdata;
   end
   assign checksum = csum;
`else
   assign checksum = 32'h0;
`endif

   assign bus.mem_req   = !fifo_empty;
   assign bus.mem_addr  = addr;
   assign bus.mem_wdata = fifo_mem[rd_ptr];
   assign busy          = (state == ST_RUN) || (state == ST_FLUSH) || (state == ST_DRAIN);
   assign done          = (state == ST_DONE);

endmodule

// File: tb/tb_sd_load_ctrl.sv
// Bench for sd_load_ctrl: directed scenarios plus randomized traffic, checked every cycle
// against a transaction-level model (byte count, word queue, ack count).
module tb_sd_load_ctrl;
   localparam int          BIN   = 10;
   localparam int          DEPTH = 2;
   localparam logic [31:0] BASE  = 32'hFFFF_FFF8;

   logic        clk27mhz = 1'b0;
   logic        resetn;
   logic        enable;
   logic        busy, done, overflow;
   logic [31:0] checksum;

   sd_load_ctrl_if bus();

   sd_load_ctrl #(.BIN_SIZE(BIN), .BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
      .clk27mhz (clk27mhz),
      .resetn   (resetn),
      .enable   (enable),
      .bus      (bus),
      .busy     (busy),
      .done     (done),
      .overflow (overflow),
      .checksum (checksum)
   );

   always #5 clk27mhz = ~clk27mhz;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   // stimulus policy
   int       ack_mode;   // 0 tied high, 1 tied low, 2 ack after 5 waiting cycles, 3 random
   int       en_mode;    // 0 high, 1 low, 2 random
   int       val_pct;
   bit       seq_bytes;
   logic [7:0] next_byte;

   // reference model
   bit          started, flush_due, m_done, m_ovf;
   int          nbytes, acks, waitc;
   logic [31:0] cur, sum;
   logic [31:0] q[$];
   logic [31:0] log_addr[$];
   logic [31:0] log_data[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_csum();
`ifdef SDLOAD_CHECKSUM_EN
      return sum;
`else
      return 32'h0;
`endif
   endfunction

   task automatic model_clear();
      started = 0; flush_due = 0; m_done = 0; m_ovf = 0;
      nbytes = 0; acks = 0; waitc = 0; cur = 0; sum = 0;
      q.delete(); log_addr.delete(); log_data.delete();
      next_byte = 8'h01;
   endtask

   // advance the model across one rising edge using the inputs currently applied
   task automatic model_edge();
      bit pop, push;
      logic [31:0] pw;
      pop  = (q.size() != 0) && bus.mem_ack;
      push = 0;
      pw   = 0;
      if (started && nbytes == BIN && !flush_due && q.size() == 0) m_done = 1;
      if (!started) begin
         if (enable) started = 1;
      end else if (flush_due) begin
         push = 1; pw = cur; cur = 0; flush_due = 0;
      end else if (nbytes < BIN && enable && bus.in_valid) begin
         cur = cur | (32'(bus.in_byte) << (8 * (nbytes % 4)));
         nbytes++;
         if (seq_bytes) next_byte = next_byte + 8'd1;
         if (nbytes % 4 == 0) begin
            push = 1; pw = cur; cur = 0;
         end else if (nbytes == BIN) flush_due = 1;
      end
      if (pop) begin
         sum = sum + q[0];
         void'(q.pop_front());
         acks++;
         waitc = 0;
      end else if (q.size() != 0) waitc++;
      if (push) begin
         if (q.size() < DEPTH) q.push_back(pw);
         else m_ovf = 1;
      end
   endtask

   task automatic drive();
      case (en_mode)
         0:       enable = 1'b1;
         1:       enable = 1'b0;
         default: enable = ($urandom_range(0, 99) < 75);
      endcase
      bus.in_valid = ($urandom_range(0, 99) < val_pct);
      bus.in_byte  = seq_bytes ? next_byte : 8'($urandom);
      case (ack_mode)
         0:       bus.mem_ack = 1'b1;
         1:       bus.mem_ack = 1'b0;
         2:       bus.mem_ack = (q.size() != 0) && (waitc == 5);
         default: bus.mem_ack = ($urandom_range(0, 99) < 40);
      endcase
   endtask

   task automatic step();
      drive();
      @(negedge clk27mhz);
      check("mem_req", bus.mem_req, q.size() != 0);
      check("mem_addr", bus.mem_addr, BASE + 32'(4 * acks));
      if (q.size() != 0) check("mem_wdata", bus.mem_wdata, q[0]);
      check("busy", busy, started && !m_done);
      check("done", done, m_done);
      check("overflow", overflow, m_ovf);
      check("checksum", checksum, exp_csum());
      if (bus.mem_req && bus.mem_ack) begin
         log_addr.push_back(bus.mem_addr);
         log_data.push_back(bus.mem_wdata);
      end
      model_edge();
      @(posedge clk27mhz);
      #1;
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic run_until_done(input int limit);
      for (int i = 0; i < limit && !m_done; i++) step();
      run(3);
      check("reached_done", done, 1'b1);
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      enable = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_byte  = 8'h00;
      bus.mem_ack  = 1'b0;
      repeat (2) @(posedge clk27mhz);
      @(negedge clk27mhz);
      check("rst_req", bus.mem_req, 1'b0);
      check("rst_addr", bus.mem_addr, BASE);
      check("rst_wdata", bus.mem_wdata, 32'h0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_ovf", overflow, 1'b0);
      check("rst_csum", checksum, 32'h0);
      model_clear();
      @(posedge clk27mhz);
      #1 resetn = 1'b1;
   endtask

   initial begin
      resetn = 1'b0;
      ack_mode = 0; en_mode = 0; val_pct = 100; seq_bytes = 1;

      // basic load with partial last word and address wrap; extra bytes after done ignored
      do_reset();
      ack_mode = 0; en_mode = 0; val_pct = 100; seq_bytes = 1;
      run_until_done(60);
      run(5);
      check("a_nwrites", log_data.size(), 3);
      check("a_w0", log_data[0], 32'h0403_0201);
      check("a_a0", log_addr[0], 32'hFFFF_FFF8);
      check("a_w1", log_data[1], 32'h0807_0605);
      check("a_a1", log_addr[1], 32'hFFFF_FFFC);
      check("a_w2", log_data[2], 32'h0000_0A09);
      check("a_a2", log_addr[2], 32'h0000_0000);
`ifdef SDLOAD_CHECKSUM_EN
      check("a_csum", checksum, 32'h0C0A_120F);
`endif

      // overflow: no acks, the padded third word is dropped, two stay queued
      do_reset();
      ack_mode = 1;
      run(20);
      check("o_ovf", overflow, 1'b1);
      check("o_req", bus.mem_req, 1'b1);
      check("o_head", bus.mem_wdata, 32'h0403_0201);
      check("o_nwrites", log_data.size(), 0);
      ack_mode = 0;
      run_until_done(20);
      check("o_nwrites2", log_data.size(), 2);
      check("o_w1", log_data[1], 32'h0807_0605);

      // back-pressure: each request waits five cycles before its ack
      do_reset();
      ack_mode = 2;
      run_until_done(200);
      check("b_nwrites", log_data.size(), 3);
      check("b_w2", log_data[2], 32'h0000_0A09);

      // enable gating, then intermittent enable with random acks
      do_reset();
      en_mode = 1; ack_mode = 3; val_pct = 100; seq_bytes = 0;
      run(15);
      check("e_nwrites", log_data.size(), 0);
      check("e_busy", busy, 1'b0);
      en_mode = 2; val_pct = 70;
      run_until_done(400);

      // randomized loads
      for (int k = 0; k < 4; k++) begin
         do_reset();
         en_mode = 2; ack_mode = 3; seq_bytes = 0;
         val_pct = $urandom_range(30, 100);
         run_until_done(400);
      end

      // asynchronous reset while a request is pending
      do_reset();
      en_mode = 0; ack_mode = 1; val_pct = 100; seq_bytes = 1;
      for (int i = 0; i < 20 && q.size() == 0; i++) step();
      check("m_req_before", bus.mem_req, 1'b1);
      #2 resetn = 1'b0;
      #1;
      check("m_req", bus.mem_req, 1'b0);
      check("m_addr", bus.mem_addr, BASE);
      check("m_done", done, 1'b0);
      check("m_busy", busy, 1'b0);
      do_reset();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
